// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared constants for the weight ROM fetch sequencer: FSM encoding and output buffer depth.
package weight_fetch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Command, ROM and output-stream signals of the weight fetch sequencer.
interface weight_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  busy;
    logic                  done;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, base_addr, count, rom_data, out_ready,
        output busy, done, rom_en, rom_addr, out_valid, out_data, out_last
    );

    modport slave (
        output start, base_addr, count, rom_data, out_ready,
        input  busy, done, rom_en, rom_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/wfc_skid_fifo.sv
// Two-entry FIFO holding returned ROM words (data plus last tag); head entry is the registered output.
module wfc_skid_fifo
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] tail;
    logic [1:0]       level;
    logic             do_pop;
    logic             do_push;

    assign full    = (level == BUF_DEPTH);
    assign empty   = (level == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (empty) head <= push_data;
                    else       tail <= push_data;
                    level <= level + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: the new word lands behind whatever remains.
                    if (level == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Reads a contiguous run of weight words from a 1-cycle-latency ROM and streams them out over valid/ready.
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    weight_fetch_ctrl_if.master bus
);
    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  rd_pend;
    logic                  rd_last;
    logic                  busy_q;
    logic                  done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   head;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            occ_eff;
    logic                  issue;
    logic                  last_issue;
    logic                  accept;
    logic                  drain_done;

    assign pop     = !fifo_empty && bus.out_ready;
    assign occ     = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    // Count the word leaving this cycle as already gone so a steady stream issues every cycle.
    assign occ_eff = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};

    assign issue      = (state == ST_FETCH) && (issued != cnt) && (occ_eff < {1'b0, BUF_DEPTH});
    assign last_issue = issue && ((issued + {{ADDR_WIDTH{1'b0}}, 1'b1}) == cnt);
    assign accept     = (state == ST_IDLE) && !done_q && bus.start;
    assign drain_done = (state == ST_DRAIN) && !rd_pend && (fifo_empty || (!fifo_full && pop));

    assign bus.rom_en    = issue;
    assign bus.rom_addr  = issue ? next_addr : last_addr;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head[DATA_WIDTH-1:0];
    assign bus.out_last  = head[DATA_WIDTH];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            issued    <= '0;
            next_addr <= '0;
            last_addr <= '0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_pend <= issue;
            rd_last <= last_issue;
            if (issue) begin
                next_addr <= next_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                last_addr <= next_addr;
                issued    <= issued + {{ADDR_WIDTH{1'b0}}, 1'b1};
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt       <= bus.count;
                        next_addr <= bus.base_addr;
                        issued    <= '0;
                        busy_q    <= 1'b1;
                        state     <= (bus.count == '0) ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (last_issue) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    wfc_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_data({rd_last, bus.rom_data}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl with a synchronous ROM model and per-scenario checks.
module tb_weight_fetch_ctrl;

    logic clk;
    logic rst;

    weight_fetch_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    weight_fetch_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] mem [16];

    int checks = 0;
    int passed = 0;

    logic [3:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    int en_cnt, valid_cnt, done_k, done_cnt, busy_k, first_en_k, first_val_k;
    int stall_viol, max_out, en_early, en_after_done;
    logic busy_after_done;

    function automatic logic [31:0] rom_word(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203 + 32'h11;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= mem[bus.rom_addr];
    end

    // mode 0: ready always; mode 1: ready 1,0,0,1; mode 2: ready low 10 cycles plus stray starts
    task automatic run_cmd(input logic [3:0] b, input logic [4:0] c, input int mode, input int max_cyc);
        int outst;
        logic prev_stall;
        logic [32:0] prev_word;
        logic hs;
        q_addr.delete(); q_data.delete(); q_last.delete();
        en_cnt = 0; valid_cnt = 0; done_k = -1; done_cnt = 0; busy_k = -1;
        first_en_k = -1; first_val_k = -1; stall_viol = 0; max_out = 0;
        en_early = 0; en_after_done = 0; busy_after_done = 1'bx;
        outst = 0; prev_stall = 1'b0; prev_word = '0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            bus.start = (k == 0) || (mode == 2 && (k == 4 || k == 8 || bus.done));
            if (k == 0) begin
                bus.base_addr = b;
                bus.count     = c;
            end else if (bus.start) begin
                bus.base_addr = 4'd9;
                bus.count     = 5'd3;
            end
            case (mode)
                1:       bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       bus.out_ready = (k > 10);
                default: bus.out_ready = 1'b1;
            endcase
            #1;
            if (bus.rom_en) begin
                q_addr.push_back(bus.rom_addr);
                en_cnt++;
                if (first_en_k < 0) first_en_k = k;
                if (k <= 10) en_early++;
                if (done_k >= 0) en_after_done++;
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_val_k < 0) first_val_k = k;
                if (prev_stall && ({bus.out_last, bus.out_data} !== prev_word)) stall_viol++;
            end
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                q_data.push_back(bus.out_data);
                q_last.push_back(bus.out_last);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = {bus.out_last, bus.out_data};
            if (bus.busy && busy_k < 0) busy_k = k;
            if (done_k >= 0 && k == done_k + 1) busy_after_done = bus.busy;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            outst = outst + (bus.rom_en ? 1 : 0) - (hs ? 1 : 0);
            if (outst > max_out) max_out = outst;
            if (done_k >= 0 && k == done_k + 2) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        checks++; if (bus.rom_en !== 1'b0) $display("FAIL reset_rom_en got %b want 0", bus.rom_en); else passed++;
        checks++; if (bus.rom_addr !== 4'd0) $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if ({bus.out_last, bus.out_data} !== 33'd0) $display("FAIL reset_out_data got %h want 0", {bus.out_last, bus.out_data}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int bad;
        run_cmd(4'd0, 5'd4, 0, 40);
        checks++; if (done_k < 0) $display("FAIL basic_timeout got no done want done"); else passed++;
        checks++; if (busy_k !== 1) $display("FAIL basic_busy_start got %0d want 1", busy_k); else passed++;
        checks++; if (first_en_k !== 1) $display("FAIL basic_first_en got %0d want 1", first_en_k); else passed++;
        checks++; if (first_val_k !== 3) $display("FAIL basic_first_valid got %0d want 3", first_val_k); else passed++;
        checks++; if (en_cnt !== 4) $display("FAIL basic_en_count got %0d want 4", en_cnt); else passed++;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (q_addr.size() <= i || q_addr[i] !== 4'(i)) bad++;
            if (q_data.size() <= i || q_data[i] !== rom_word(i)) bad++;
            if (q_last.size() <= i || q_last[i] !== (i == 3)) bad++;
        end
        checks++; if (bad !== 0 || q_data.size() !== 4) $display("FAIL basic_stream got %0d bad words (%0d words) want 0 bad (4 words)", bad, q_data.size()); else passed++;
        checks++; if (done_k !== 7) $display("FAIL basic_done_cycle got %0d want 7", done_k); else passed++;
        checks++; if (busy_after_done !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy_after_done); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_wrap;
        int bad;
        run_cmd(4'd14, 5'd4, 0, 40);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (q_addr.size() <= i || q_addr[i] !== 4'((14 + i) % 16)) bad++;
            if (q_data.size() <= i || q_data[i] !== rom_word((14 + i) % 16)) bad++;
            if (q_last.size() <= i || q_last[i] !== (i == 3)) bad++;
        end
        checks++; if (bad !== 0 || q_addr.size() !== 4) $display("FAIL wrap_stream got %0d bad (%0d addrs) want 0 bad (4 addrs)", bad, q_addr.size()); else passed++;
        checks++; if (done_k !== 7) $display("FAIL wrap_done_cycle got %0d want 7", done_k); else passed++;
    endtask

    task automatic test_full_rom_backpressure;
        int bad;
        run_cmd(4'd0, 5'd16, 1, 200);
        checks++; if (q_data.size() !== 16) $display("FAIL full_word_count got %0d want 16", q_data.size()); else passed++;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (q_data.size() <= i || q_data[i] !== rom_word(i)) bad++;
            if (q_last.size() <= i || q_last[i] !== (i == 15)) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL full_order got %0d bad want 0", bad); else passed++;
        checks++; if (en_cnt !== 16) $display("FAIL full_en_count got %0d want 16", en_cnt); else passed++;
        checks++; if (stall_viol !== 0) $display("FAIL full_stall_stable got %0d changes want 0", stall_viol); else passed++;
        checks++; if (max_out > 2) $display("FAIL full_outstanding got %0d want <=2", max_out); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL full_done_count got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_zero_count;
        run_cmd(4'd2, 5'd0, 0, 20);
        checks++; if (en_cnt !== 0) $display("FAIL zero_rom_en got %0d want 0", en_cnt); else passed++;
        checks++; if (valid_cnt !== 0) $display("FAIL zero_out_valid got %0d want 0", valid_cnt); else passed++;
        checks++; if (busy_k !== 1) $display("FAIL zero_busy_start got %0d want 1", busy_k); else passed++;
        checks++; if (done_k !== 2) $display("FAIL zero_done_cycle got %0d want 2", done_k); else passed++;
        checks++; if (busy_after_done !== 1'b0) $display("FAIL zero_busy_after got %b want 0", busy_after_done); else passed++;
    endtask

    task automatic test_stall_start_ignored;
        int bad;
        run_cmd(4'd3, 5'd8, 2, 100);
        checks++; if (en_early !== 2) $display("FAIL stall_reads_while_blocked got %0d want 2", en_early); else passed++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (q_addr.size() <= i || q_addr[i] !== 4'(3 + i)) bad++;
            if (q_data.size() <= i || q_data[i] !== rom_word(3 + i)) bad++;
            if (q_last.size() <= i || q_last[i] !== (i == 7)) bad++;
        end
        checks++; if (bad !== 0 || q_data.size() !== 8) $display("FAIL stall_stream got %0d bad (%0d words) want 0 bad (8 words)", bad, q_data.size()); else passed++;
        checks++; if (en_cnt !== 8) $display("FAIL stall_en_count got %0d want 8", en_cnt); else passed++;
        checks++; if (stall_viol !== 0) $display("FAIL stall_stable got %0d changes want 0", stall_viol); else passed++;
        checks++; if (done_k !== 19) $display("FAIL stall_done_cycle got %0d want 19", done_k); else passed++;
        checks++; if (busy_after_done !== 1'b0) $display("FAIL stall_start_in_done_cycle busy got %b want 0", busy_after_done); else passed++;
        checks++; if (en_after_done !== 0) $display("FAIL stall_reads_after_done got %0d want 0", en_after_done); else passed++;
    endtask

    task automatic test_reset_midrun;
        int spur;
        int bad;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 4'd0; bus.count = 5'd8; bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        checks++; if (!(bus.busy === 1'b1 && bus.out_valid === 1'b1)) $display("FAIL midrun_active got busy=%b valid=%b want 1/1", bus.busy, bus.out_valid); else passed++;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else passed++;
        checks++; if (bus.rom_en !== 1'b0) $display("FAIL abort_rom_en got %b want 0", bus.rom_en); else passed++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if ({bus.out_last, bus.out_data} !== 33'd0) $display("FAIL abort_out_data got %h want 0", {bus.out_last, bus.out_data}); else passed++;
        checks++; if (bus.rom_addr !== 4'd0) $display("FAIL abort_rom_addr got %0d want 0", bus.rom_addr); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spur = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy || bus.rom_en || bus.out_valid) spur++;
        end
        checks++; if (spur !== 0) $display("FAIL abort_no_done got %0d active cycles want 0", spur); else passed++;
        run_cmd(4'd5, 5'd2, 0, 40);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            if (q_data.size() <= i || q_data[i] !== rom_word(5 + i)) bad++;
            if (q_last.size() <= i || q_last[i] !== (i == 1)) bad++;
        end
        checks++; if (bad !== 0 || q_data.size() !== 2) $display("FAIL restart_stream got %0d bad (%0d words) want 0 bad (2 words)", bad, q_data.size()); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL restart_done_count got %0d want 1", done_cnt); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = rom_word(i);
        test_reset();
        test_basic();
        test_wrap();
        test_full_rom_backpressure();
        test_zero_count();
        test_stall_start_ignored();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Sequencer for the synchronous weight ROM (ports en/addr/data, 1-cycle read latency). On a start command it reads a contiguous run of weight words from a given base address and streams them to a downstream PE cell over a valid/ready interface. Absorbs consumer backpressure with a 2-entry output buffer so no ROM read is lost, and signals completion. Sits between the layer scheduler and one conv2d cell's weight ROM.

Parameters:
ADDR_WIDTH, 4, ROM address width; ROM depth is 2^ADDR_WIDTH words
DATA_WIDTH, 32, ROM word width (packed int8 weights)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_WIDTH  first ROM address, captured on accepted start
count  in  ADDR_WIDTH+1  words to fetch, 0..2^ADDR_WIDTH, captured on accepted start
busy  out  1  high from accepted start until done
done  out  1  single-cycle pulse after last word handed off
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_WIDTH  ROM read address
rom_data  in  DATA_WIDTH  ROM read data, valid the cycle after rom_en=1
out_valid  out  1  stream word valid
out_data  out  DATA_WIDTH  stream word
out_last  out  1  marks final word of the run, qualified by out_valid
out_ready  in  1  consumer accepts when out_valid && out_ready

Behaviour:
- Reset (async assert, any time): state=IDLE; busy=0, done=0, rom_en=0, rom_addr=0, out_valid=0, out_last=0, out_data=0; buffer emptied, counters cleared. In-flight ROM read discarded. No done pulse for an aborted run.
- States: IDLE, FETCH, DRAIN.
- IDLE: start=1 -> capture base_addr/count; count=0 -> go to DRAIN with nothing to emit, done pulses next cycle; else -> FETCH. busy=1 from the cycle after start. start while busy ignored.
- FETCH: issue rom_en=1, rom_addr=next address, whenever (buffer occupancy + reads in flight) < 2. Max one read issued per cycle; sustained throughput 1 word/cycle when out_ready=1. Address increments modulo 2^ADDR_WIDTH (base 14, count 4 -> 14,15,0,1). After count reads issued -> DRAIN.
- Read data captured into the buffer the cycle after issue; each word tagged last when it is issued read number count.
- Buffer: 2-entry FIFO, out_data/out_valid/out_last driven from the head entry (registered, no combinational path from out_ready to rom_en other than through occupancy). Word order preserved exactly. out_data/out_last held stable while out_valid && !out_ready.
- Simultaneous push and pop: occupancy unchanged, both permitted.
- DRAIN: no reads; when buffer empty and no read in flight -> done=1 for one cycle, busy=0, back to IDLE. start in the done cycle is ignored (accepted earliest the following cycle).
- rom_en=0 whenever no read is issued; rom_addr holds last issued value.
- Latency: start cycle T -> first rom_en at T+1 -> first out_valid at T+3 (read issue at T+1, data at T+2, buffer registered at T+3).
- Counters ADDR_WIDTH+1 bits so count=2^ADDR_WIDTH (full ROM) works.

Decomposition:
- Shared package: state encoding constants (IDLE/FETCH/DRAIN), buffer depth constant (2).
- One sub-module natural: wfc_skid_fifo, 2-entry DATA_WIDTH+1 (data+last) FIFO with push/pop/full/empty; controller holds FSM, address/issue/return counters.

Test Plan:
- base=0, count=4, out_ready=1 -> rom_addr 0,1,2,3 on consecutive cycles; out_data = mem[0..3] back-to-back, out_last only on word 4; done one cycle after last handshake; busy low after.
- base=14, count=4 -> rom_addr 14,15,0,1; stream mem[14],mem[15],mem[0],mem[1].
- count=16 (full ROM), out_ready toggling 1,0,0,1 pattern -> all 16 words in order, none dropped/duplicated, out_data stable while stalled, never more than 2 reads outstanding+buffered.
- count=0 -> no rom_en, no out_valid, done pulse one cycle after busy asserted.
- out_ready=0 for 10 cycles after start (count=8) -> rom_en stops after 2 reads; resumes on out_ready=1; full sequence correct; start pulses during run ignored.
- rst asserted mid-run (after 3 words of count=8) -> outputs zero immediately (async), no done; new start base=5,count=2 afterwards streams mem[5],mem[6] cleanly.
